// File: rtl/fb_reader.sv
// Frame-buffer read side: fetches the stored (possibly resized) image in display-scan order,
// centres it in the active raster and fills the surround with a border colour.
module fb_reader #(
    parameter int CAM_DATA_WIDTH = 12,
    parameter int CAM_LINE       = 9,
    parameter int CAM_PIXEL      = 10,
    parameter int ADDR_WIDTH     = 19,
    parameter int DISP_WIDTH     = 640,
    parameter int DISP_DEPTH     = 480,
    parameter int READ_LATENCY   = 1,
    parameter logic [CAM_DATA_WIDTH-1:0] BORDER = 12'h000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_de,
    input  logic [CAM_PIXEL-1:0]      i_hcount,
    input  logic [CAM_LINE-1:0]       i_vcount,
    input  logic [CAM_PIXEL-1:0]      i_imag_width,
    input  logic [CAM_LINE-1:0]       i_imag_depth,
    input  logic                      i_imag_resized,
    output logic                      o_re,
    output logic [ADDR_WIDTH-1:0]     o_addr,
    input  logic [CAM_DATA_WIDTH-1:0] i_rdata,
    output logic                      o_de,
    output logic [CAM_DATA_WIDTH-1:0] o_data,
    output logic                      o_err
);

    typedef enum logic [0:0] {S_SYNC, S_RUN} state_t;

    localparam int PIPE = READ_LATENCY + 1;
    localparam logic [CAM_PIXEL:0] DISP_W = (CAM_PIXEL+1)'(DISP_WIDTH);
    localparam logic [CAM_LINE:0]  DISP_D = (CAM_LINE+1)'(DISP_DEPTH);

    state_t                  state;
    logic [CAM_PIXEL:0]      geo_w, geo_xoff;
    logic [CAM_LINE:0]       geo_d, geo_yoff;
    logic                    geo_err;
    logic [ADDR_WIDTH-1:0]   addr_cnt;
    logic [PIPE-1:0]         de_pipe, win_pipe;

    logic                    fs;
    logic [CAM_PIXEL:0]      new_w, new_xoff, cur_w, cur_xoff, h_ext;
    logic [CAM_LINE:0]       new_d, new_yoff, cur_d, cur_yoff, v_ext;
    logic                    new_err, cur_err, in_win;
    logic [ADDR_WIDTH-1:0]   addr_base;

    // The frame-start cycle already uses the geometry it is about to latch.
    always_comb begin
        fs       = i_de && (i_hcount == '0) && (i_vcount == '0);
        new_w    = i_imag_resized ? {1'b0, i_imag_width} : DISP_W;
        new_d    = i_imag_resized ? {1'b0, i_imag_depth} : DISP_D;
        new_err  = (new_w == '0) || (new_d == '0) || (new_w > DISP_W) || (new_d > DISP_D);
        new_xoff = (DISP_W - new_w) >> 1;
        new_yoff = (DISP_D - new_d) >> 1;

        cur_w    = fs ? new_w    : geo_w;
        cur_d    = fs ? new_d    : geo_d;
        cur_xoff = fs ? new_xoff : geo_xoff;
        cur_yoff = fs ? new_yoff : geo_yoff;
        cur_err  = fs ? new_err  : geo_err;

        h_ext    = {1'b0, i_hcount};
        v_ext    = {1'b0, i_vcount};
        in_win   = ((state == S_RUN) || fs) && i_de && !cur_err
                   && (h_ext >= cur_xoff) && (h_ext < cur_xoff + cur_w)
                   && (v_ext >= cur_yoff) && (v_ext < cur_yoff + cur_d);
        addr_base = fs ? '0 : addr_cnt;
    end

    // Window pixels arrive in row-major order, so a plain counter yields the linear address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_SYNC;
            geo_w    <= '0;
            geo_d    <= '0;
            geo_xoff <= '0;
            geo_yoff <= '0;
            geo_err  <= 1'b0;
            addr_cnt <= '0;
            de_pipe  <= '0;
            win_pipe <= '0;
            o_re     <= 1'b0;
            o_addr   <= '0;
            o_de     <= 1'b0;
            o_data   <= '0;
        end else begin
            case (state)
                S_SYNC:  if (fs) state <= S_RUN;
                S_RUN:   state <= S_RUN;
                default: state <= S_SYNC;
            endcase

            if (fs) begin
                geo_w    <= new_w;
                geo_d    <= new_d;
                geo_xoff <= new_xoff;
                geo_yoff <= new_yoff;
                geo_err  <= new_err;
            end

            o_re     <= in_win;
            if (in_win)
                o_addr <= addr_base;
            addr_cnt <= addr_base + ADDR_WIDTH'(in_win);

            de_pipe  <= {de_pipe[PIPE-2:0], i_de};
            win_pipe <= {win_pipe[PIPE-2:0], in_win};
            o_de     <= de_pipe[PIPE-1];
            o_data   <= !de_pipe[PIPE-1] ? '0 : (win_pipe[PIPE-1] ? i_rdata : BORDER);
        end
    end

    assign o_err = geo_err;

endmodule
